// File: rtl/ifmap_bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_bram_loader_pkg
// Purpose  : Shared GEMM buffer geometry and the loader FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ifmap_bram_loader_pkg;

  // Stream element and PE array geometry
  localparam int GEMM_DATA_WIDTH  = 8;
  localparam int GEMM_PE_SIZE     = 14;

  // BRAM0: ifmap buffer
  localparam int BRAM0_DEPTH      = 4116;
  localparam int BRAM0_ADDR_WIDTH = 13;
  localparam int BRAM0_DATA_WIDTH = GEMM_PE_SIZE * GEMM_DATA_WIDTH;

  // BRAM1: weight buffer
  localparam int BRAM1_DEPTH      = 1470;
  localparam int BRAM1_ADDR_WIDTH = 11;
  localparam int BRAM1_DATA_WIDTH = GEMM_PE_SIZE * GEMM_DATA_WIDTH;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

endpackage : ifmap_bram_loader_pkg
`default_nettype wire

// File: rtl/ifmap_bram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_bram_loader_if
// Purpose  : Byte-stream valid/ready handshake feeding the BRAM loader.
// Revision : 1.0 - initial release
// ============================================================================
interface ifmap_bram_loader_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_ready_o;

  // Stream producer side
  modport master (
    output s_data_i,
    output s_valid_i,
    output s_last_i,
    input  s_ready_o
  );

  // Loader side
  modport slave (
    input  s_data_i,
    input  s_valid_i,
    input  s_last_i,
    output s_ready_o
  );

endinterface : ifmap_bram_loader_if
`default_nettype wire

// File: rtl/ifmap_bram_loader_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_bram_loader_lane_packer
// Purpose  : Shifts stream elements into a PE_SIZE-lane word; lane 0 ends up
//            in the LSBs. Flags the element that completes a word.
// Revision : 1.0 - initial release
// ============================================================================
module ifmap_bram_loader_lane_packer
  import ifmap_bram_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = GEMM_DATA_WIDTH,
  parameter int PE_SIZE        = GEMM_PE_SIZE,
  parameter int MEM_DATA_WIDTH = PE_SIZE * DATA_WIDTH
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      clear,
  input  wire logic                      shift_en,
  input  wire logic [DATA_WIDTH-1:0]     data,
  output logic                           word_valid,
  output logic [MEM_DATA_WIDTH-1:0]      word
);

  localparam int LANE_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(PE_SIZE - 1);

  logic [LANE_W-1:0]         r_lane;
  logic [MEM_DATA_WIDTH-1:0] r_pack;

  // New element enters at the top; after PE_SIZE shifts the first one sits in lane 0
  assign word       = {data, r_pack[MEM_DATA_WIDTH-1:DATA_WIDTH]};
  assign word_valid = shift_en && (r_lane == C_LAST_LANE);

  // Lane counter and pack register; clear wins so an aborted word is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (clear) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (shift_en) begin
      r_lane <= (r_lane == C_LAST_LANE) ? '0 : r_lane + 1'b1;
      r_pack <= word;
    end
  end

endmodule : ifmap_bram_loader_lane_packer
`default_nettype wire

// File: rtl/ifmap_bram_loader.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_bram_loader
// Purpose  : Packs a byte stream into BRAM words, writes them to consecutive
//            addresses, then pulses gemm_start_o. Flags s_last_i framing errors.
// Revision : 1.0 - initial release
// ============================================================================
module ifmap_bram_loader
  import ifmap_bram_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = GEMM_DATA_WIDTH,
  parameter int PE_SIZE        = GEMM_PE_SIZE,
  parameter int MEM_DATA_WIDTH = BRAM0_DATA_WIDTH,
  parameter int MEM_DEPTH      = BRAM0_DEPTH,
  parameter int MEM_ADDR_WIDTH = BRAM0_ADDR_WIDTH
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      load_start_i,
  ifmap_bram_loader_if.slave             s_stream,
  output logic                           mem_ce0,
  output logic                           mem_we0,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_addr0,
  output logic [MEM_DATA_WIDTH-1:0]      mem_d0,
  output logic                           busy_o,
  output logic                           gemm_start_o,
  output logic                           err_o
);

  localparam logic [MEM_ADDR_WIDTH-1:0] C_LAST_WORD = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  load_state_t               r_state;
  load_state_t               w_next;
  logic                      w_ready;
  logic                      w_busy;
  logic                      w_gemm_start;
  logic                      w_xfer;
  logic                      w_start;
  logic                      w_word_valid;
  logic [MEM_DATA_WIDTH-1:0] w_word;
  logic                      w_final;
  logic                      w_abort;
  logic                      w_write;
  logic                      w_pack_clear;

  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_DATA_WIDTH-1:0] r_d;
  logic [MEM_ADDR_WIDTH-1:0] r_word_cnt;
  logic                      r_err;

  assign w_ready = (r_state == ST_LOAD);
  assign w_xfer  = s_stream.s_valid_i && w_ready;
  assign w_start = (r_state == ST_IDLE) && load_start_i;

  // Element that completes the last word of the load
  assign w_final = w_word_valid && (r_word_cnt == C_LAST_WORD);
  // s_last_i before the final element aborts; the word it belongs to is never written
  assign w_abort = w_xfer && s_stream.s_last_i && !w_final;
  assign w_write = w_word_valid && !w_abort;
  assign w_pack_clear = w_start || w_abort;

  ifmap_bram_loader_lane_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PE_SIZE        (PE_SIZE),
    .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
  ) u_lane_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_pack_clear),
    .shift_en   (w_xfer),
    .data       (s_stream.s_data_i),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b0;
    w_gemm_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start_i) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_busy = 1'b1;
        if (w_abort)      w_next = ST_IDLE;
        else if (w_final) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_busy = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_gemm_start = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // BRAM write port, word address counter and sticky framing error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_d        <= '0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr <= r_word_cnt;
        r_d    <= w_word;
        // Counter parks on the last address instead of wrapping
        if (r_word_cnt != C_LAST_WORD) r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_start) begin
        r_word_cnt <= '0;
        r_err      <= 1'b0;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end else if (w_final && !s_stream.s_last_i) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_stream.s_ready_o = w_ready;
  assign mem_ce0      = r_we;
  assign mem_we0      = r_we;
  assign mem_addr0    = r_addr;
  assign mem_d0       = r_d;
  assign busy_o       = w_busy;
  assign gemm_start_o = w_gemm_start;
  assign err_o        = r_err;

endmodule : ifmap_bram_loader
`default_nettype wire

// File: tb/tb_ifmap_bram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifmap_bram_loader
// Purpose  : Scoreboard bench for ifmap_bram_loader (PE_SIZE=4, MEM_DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifmap_bram_loader;

  localparam int DW    = 8;
  localparam int PE    = 4;
  localparam int MDW   = 32;
  localparam int DEPTH = 3;
  localparam int AW    = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_start_i = 1'b0;
  logic           mem_ce0, mem_we0, busy_o, gemm_start_o, err_o;
  logic [AW-1:0]  mem_addr0;
  logic [MDW-1:0] mem_d0;

  ifmap_bram_loader_if #(.DATA_WIDTH(DW)) sif ();

  ifmap_bram_loader #(
    .DATA_WIDTH     (DW),
    .PE_SIZE        (PE),
    .MEM_DATA_WIDTH (MDW),
    .MEM_DEPTH      (DEPTH),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .s_stream     (sif),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .mem_addr0    (mem_addr0),
    .mem_d0       (mem_d0),
    .busy_o       (busy_o),
    .gemm_start_o (gemm_start_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Hand-computed words for stream 0x01..0x0C, lane 0 in the LSBs
  logic [MDW-1:0] golden [DEPTH] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_hs = -100;
  logic [63:0] exp_wr [$];
  int          pulse_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] wr_key(input logic we, input logic [AW-1:0] a, input logic [MDW-1:0] d);
    return {29'b0, we, a, d};
  endfunction

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++) exp_wr.push_back(wr_key(1'b1, AW'(w), golden[w]));
  endtask

  // Monitor: pops expected writes / pulses whenever the DUT presents one
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.s_valid_i && sif.s_ready_o) last_hs = cyc;
      if (mem_ce0) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=none", mem_addr0, mem_d0);
        end else begin
          check("bram_write", wr_key(mem_we0, mem_addr0, mem_d0), exp_wr.pop_front());
        end
      end
      if (gemm_start_o) begin
        if (pulse_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gemm_start actual=1 required=0 at cycle %0d", cyc);
        end else begin
          void'(pulse_q.pop_front());
          check("pulse_latency", 64'(cyc - last_hs), 64'd2);
        end
      end
    end
  end

  task automatic start_load();
    @(posedge clk); #1;
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  // Send elements 1..n; last_at marks s_last_i, ls_at pulses load_start_i alongside
  task automatic stream(input int n, input int last_at, input bit gap, input int ls_at);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        sif.s_valid_i = 1'b0;
        sif.s_last_i  = 1'b0;
        @(posedge clk); #1;
      end
      sif.s_data_i  = DW'(i + 1);
      sif.s_valid_i = 1'b1;
      sif.s_last_i  = (i == last_at);
      load_start_i  = (i == ls_at);
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 20) begin
        @(negedge clk);
        acc = sif.s_ready_o;
        @(posedge clk); #1;
        load_start_i = 1'b0;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL handshake_timeout element=%0d actual=not_ready required=ready", i);
      end
    end
    sif.s_valid_i = 1'b0;
    sif.s_last_i  = 1'b0;
  endtask

  task automatic settle(input string tag, input logic exp_err);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_writes_pending"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_pulse_pending"}, 64'(pulse_q.size()), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    check({tag, "_idle"}, {62'b0, busy_o, sif.s_ready_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.s_data_i  = '0;
    sif.s_valid_i = 1'b0;
    sif.s_last_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {24'b0, busy_o, sif.s_ready_o, mem_ce0, mem_we0, mem_addr0, mem_d0, gemm_start_o, err_o}, 64'd0);
    rst = 1'b0;

    // Back-to-back clean load
    push_words(3); pulse_q.push_back(1);
    start_load();
    stream(12, 11, 1'b0, -1);
    settle("b2b", 1'b0);

    // Valid toggling 1-0-1-0
    push_words(3); pulse_q.push_back(1);
    start_load();
    stream(12, 11, 1'b1, -1);
    settle("gap", 1'b0);

    // Early s_last_i on element 6: abort after addr0
    push_words(1);
    start_load();
    stream(6, 5, 1'b0, -1);
    check("abort_ready", 64'(sif.s_ready_o), 64'd0);
    check("abort_err", 64'(err_o), 64'd1);
    settle("abort", 1'b1);
    push_words(3); pulse_q.push_back(1);
    start_load();
    check("err_cleared", 64'(err_o), 64'd0);
    stream(12, 11, 1'b0, -1);
    settle("recover", 1'b0);

    // Final element without s_last_i
    push_words(3); pulse_q.push_back(1);
    start_load();
    stream(12, -1, 1'b0, -1);
    settle("nolast", 1'b1);

    // Asynchronous reset mid-word after element 5
    push_words(1);
    start_load();
    stream(5, -1, 1'b0, -1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {24'b0, busy_o, sif.s_ready_o, mem_ce0, mem_we0, mem_addr0, mem_d0, gemm_start_o, err_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    settle("reset", 1'b0);
    push_words(3); pulse_q.push_back(1);
    start_load();
    stream(12, 11, 1'b0, -1);
    settle("restart", 1'b0);

    // load_start_i during LOAD (element 4) and during DONE is ignored
    push_words(3); pulse_q.push_back(1);
    start_load();
    stream(12, 11, 1'b0, 3);
    @(posedge clk); #1;
    check("done_pulse", 64'(gemm_start_o), 64'd1);
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
    check("done_start_ignored", {62'b0, busy_o, sif.s_ready_o}, 64'd0);
    settle("ignore", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifmap_bram_loader
`default_nettype wire
